// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter family: FSM states, parity helper and
// legal data-width range.
package uart_pkg;

  localparam int unsigned DataWMin = 5;
  localparam int unsigned DataWMax = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Zero-extension to DataWMax does not change the XOR reduction.
  function automatic logic calc_parity(input logic [DataWMax-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// Upstream valid/ready word handshake between a producer and the UART transmitter.
interface uart_tx_fifo_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full, pop when empty.
module uart_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned LvlW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    wptr_d  = push_ok ? wptr_q + AddrW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + AddrW'(1) : rptr_q;
    level_d = level_q;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with input FIFO, baud divider, selectable bit order,
// optional parity and one or two stop bits.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_fifo_param_if.slave           s_if,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          two_stop_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned BitW = $clog2(DATA_W);

  if (DATA_W < DataWMin || DATA_W > DataWMax) begin : gen_bad_data_w
    $error("uart_tx_fifo_param: DATA_W out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic                    fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0]       fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  uart_sync_fifo #(
    .Width (DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s_if.s_valid),
    .wdata_i (s_if.s_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign s_if.s_ready = ~fifo_full;

  uart_state_e       state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_m1_q, div_m1_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              tx_q, tx_d;
  logic              stop2_q, stop2_d;
  logic              par_bit_q, par_bit_d;
  logic              par_en_q, par_en_d;
  logic              two_stop_q, two_stop_d;

  logic [DIV_W-1:0]  baud_m1;
  logic [DATA_W-1:0] sh_next;
  logic              head_bit, next_bit, bit_end, last_bit, load;

  // A divider of 0 behaves as 1, so the per-bit reload value saturates at 0.
  assign baud_m1  = (baud_div_i == '0) ? '0 : baud_div_i - DIV_W'(1);
  assign sh_next  = MSB_FIRST ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};
  assign head_bit = MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0];
  assign next_bit = MSB_FIRST ? sh_next[DATA_W-1] : sh_next[0];
  assign bit_end  = (cnt_q == '0);
  assign last_bit = (bit_q == BitW'(DATA_W - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_m1_d   = div_m1_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    tx_d       = tx_q;
    stop2_d    = stop2_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    load       = 1'b0;
    fifo_pop   = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? div_m1_q : cnt_q - DIV_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        load = ~fifo_empty;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = head_bit;
        end
      end
      StData: begin
        if (bit_end) begin
          if (!last_bit) begin
            bit_d = bit_q + BitW'(1);
            sh_d  = sh_next;
            tx_d  = next_bit;
          end else if (par_en_q) begin
            state_d = StParity;
            tx_d    = par_bit_q;
          end else begin
            state_d = StStop;
            stop2_d = 1'b0;
            tx_d    = 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          stop2_d = 1'b0;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Word and line configuration are captured together so mid-frame changes are ignored.
    if (load) begin
      fifo_pop   = 1'b1;
      state_d    = StStart;
      tx_d       = 1'b0;
      sh_d       = fifo_rdata;
      cnt_d      = baud_m1;
      div_m1_d   = baud_m1;
      par_en_d   = parity_en_i;
      two_stop_d = two_stop_i;
      par_bit_d  = calc_parity(DataWMax'(fifo_rdata), parity_odd_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_m1_q   <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
      stop2_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_m1_q   <= div_m1_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      stop2_q    <= stop2_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != StIdle) | (fifo_level != '0);
  assign fifo_level_o = fifo_level;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench: stimulus queues expected frames, a line monitor decodes tx and compares.
module tb_uart_tx_fifo_param;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DIV_W      = 16;
  localparam bit          MSB_FIRST  = 1'b0;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          period;
    bit          b2b;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DIV_W-1:0] baud_div;
  logic parity_en, parity_odd, two_stop;
  logic tx, busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  int n_tests = 0;
  int n_fail  = 0;
  frame_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo_param_if #(.DATA_W(DATA_W)) s_if ();

  uart_tx_fifo_param #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W),
    .MSB_FIRST  (MSB_FIRST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_if         (s_if),
    .baud_div_i   (baud_div),
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .two_stop_i   (two_stop),
    .tx_o         (tx),
    .busy_o       (busy),
    .fifo_level_o (fifo_level)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line sequence for a word under the current configuration.
  function automatic frame_t make_frame(input logic [DATA_W-1:0] w, input bit b2b);
    frame_t f;
    int ones;
    f.bits = '0;
    f.nbits = 0;
    f.b2b = b2b;
    f.period = (baud_div == 0) ? 1 : int'(baud_div);
    f.bits[f.nbits++] = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      f.bits[f.nbits++] = MSB_FIRST ? w[DATA_W-1-i] : w[i];
    end
    if (parity_en) begin
      ones = $countones(w);
      f.bits[f.nbits++] = ((ones % 2) == 1) ^ parity_odd;
    end
    f.bits[f.nbits++] = 1'b1;
    if (two_stop) f.bits[f.nbits++] = 1'b1;
    return f;
  endfunction

  task automatic push_word(input logic [DATA_W-1:0] w, input bit b2b, output int lvl);
    int n = 0;
    @(negedge clk);
    s_if.s_valid = 1'b1;
    s_if.s_data  = w;
    while (!s_if.s_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    lvl = int'(fifo_level);
    if (n >= 5000) begin
      check("push_timeout", n, 0);
    end else begin
      exp_q.push_back(make_frame(w, b2b));
    end
    @(posedge clk);
    #1;
    s_if.s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("idle_timeout", n, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tx_low();
    int n = 0;
    @(negedge clk);
    while (tx && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("tx_low_timeout", n, 0);
  endtask

  // Line monitor: decodes each frame cycle by cycle against the scoreboard head.
  initial begin : monitor
    frame_t f;
    logic [15:0] got;
    bit glitch, aborted;
    int idle_cnt = 0;
    int k;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", 1, 0);
          k = 0;
          while (tx === 1'b0 && k < 5000) begin
            @(negedge clk);
            k++;
          end
        end else begin
          f = exp_q.pop_front();
          if (f.b2b) check("b2b_gap", idle_cnt, 0);
          got = '0;
          glitch = 1'b0;
          aborted = 1'b0;
          for (int b = 0; b < f.nbits; b++) begin
            for (int c = 0; c < f.period; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (!rst_n) begin
                aborted = 1'b1;
                break;
              end
              if (c == 0) got[b] = tx;
              else if (tx !== got[b]) glitch = 1'b1;
            end
            if (aborted) break;
          end
          if (!aborted) begin
            check("frame_bits", int'(got), int'(f.bits));
            check("bit_hold", int'(glitch), 0);
          end
        end
        idle_cnt = 0;
      end else begin
        idle_cnt++;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int lvl, lows, nw;
    logic [DATA_W-1:0] w;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    baud_div = 16'd4;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    two_stop = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(s_if.s_ready), 1);
    check("rst_level", int'(fifo_level), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 at 4 clocks/bit: latency and busy window.
    push_word(8'hA5, 1'b0, lvl);
    @(negedge clk);
    check("lat_n1_tx", int'(tx), 1);
    check("lat_n1_level", int'(fifo_level), 1);
    check("lat_n1_busy", int'(busy), 1);
    @(negedge clk);
    check("lat_n2_tx", int'(tx), 0);
    check("lat_n2_level", int'(fifo_level), 0);
    repeat (39) @(negedge clk);
    check("last_stop_busy", int'(busy), 1);
    check("last_stop_tx", int'(tx), 1);
    @(negedge clk);
    check("busy_drop", int'(busy), 0);
    wait_idle();

    // Parity variants.
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push_word(8'hA5, 1'b0, lvl);
    wait_idle();
    parity_odd = 1'b1;
    push_word(8'hA5, 1'b0, lvl);
    wait_idle();
    parity_odd = 1'b0;
    push_word(8'h01, 1'b0, lvl);
    wait_idle();

    // 8N2 with divider 0.
    parity_en = 1'b0;
    two_stop = 1'b1;
    baud_div = '0;
    push_word(8'h3C, 1'b0, lvl);
    wait_idle();

    // Burst of 5 then a sixth that must wait for a free slot.
    two_stop = 1'b0;
    baud_div = 16'd2;
    for (int i = 0; i < 5; i++) push_word(DATA_W'(8'h10 + i), i != 0, lvl);
    @(negedge clk);
    check("burst_level", int'(fifo_level), FIFO_DEPTH);
    check("burst_ready", int'(s_if.s_ready), 0);
    push_word(8'hE7, 1'b1, lvl);
    check("full_accept_level", lvl, FIFO_DEPTH - 1);
    @(negedge clk);
    check("refill_level", int'(fifo_level), FIFO_DEPTH);
    wait_idle();

    // Mid-frame configuration change.
    baud_div = 16'd4;
    parity_en = 1'b0;
    push_word(8'h5A, 1'b0, lvl);
    wait_tx_low();
    repeat (6) @(negedge clk);
    baud_div = 16'd8;
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push_word(8'hC3, 1'b1, lvl);
    wait_idle();

    // Reset during data bit 3.
    baud_div = 16'd4;
    parity_en = 1'b0;
    push_word(8'h96, 1'b0, lvl);
    push_word(8'h11, 1'b1, lvl);
    push_word(8'h22, 1'b1, lvl);
    wait_tx_low();
    repeat (17) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", int'(tx), 1);
    check("midrst_level", int'(fifo_level), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(s_if.s_ready), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("idle_after_reset", lows, 0);
    push_word(8'h81, 1'b0, lvl);
    wait_idle();

    // Randomised bursts with random line configuration.
    for (int it = 0; it < 25; it++) begin
      baud_div = DIV_W'($urandom_range(0, 5));
      parity_en = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      two_stop = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 5);
      for (int i = 0; i < nw; i++) begin
        w = DATA_W'($urandom);
        push_word(w, i != 0, lvl);
      end
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
